// File: rtl/wb_commit.sv
// Writeback commit stage: registers per-channel regfile writes, squashes
// channels younger than the first exit, resolves same-rd write collisions
// in favour of the youngest channel, counts retirements and latches the
// exit PC / exit code when the machine halts.
module wb_commit #(
   parameter int XLEN  = 64,
   parameter int NPORT = 2,
   parameter int CNT_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NPORT-1:0]      valid_i,
   output logic                  ready_o,
   input  logic [NPORT-1:0]      rf_wen_i,
   input  logic [NPORT*5-1:0]    rd_i,
   input  logic [NPORT*XLEN-1:0] rf_wdata_i,
   input  logic [NPORT*XLEN-1:0] pc_i,
   input  logic [NPORT-1:0]      exit_i,
   input  logic [XLEN-1:0]       a0_i,
   output logic [NPORT-1:0]      rf_wen_o,
   output logic [NPORT*5-1:0]    rd_o,
   output logic [NPORT*XLEN-1:0] rf_wdata_o,
   output logic                  halted_o,
   output logic                  good_trap_o,
   output logic [XLEN-1:0]       exit_pc_o,
   output logic [XLEN-1:0]       exit_code_o,
   output logic [CNT_W-1:0]      retired_o
);

   typedef enum logic {RUN, HALT} state_t;

   state_t                state_q, state_d;
   logic [NPORT-1:0]      acc, commit, wen_raw;
   logic [NPORT-1:0]      wen_d, wen_q;
   logic [NPORT*5-1:0]    rd_d, rd_q;
   logic [NPORT*XLEN-1:0] wdata_d, wdata_q;
   logic                  good_d, good_q;
   logic [XLEN-1:0]       exit_pc_d, exit_pc_q;
   logic [XLEN-1:0]       exit_code_d, exit_code_q;
   logic [CNT_W-1:0]      retired_d, retired_q;
   logic [CNT_W-1:0]      n_commit;
   logic                  exit_any;
   logic [XLEN-1:0]       exit_pc_sel;

   assign ready_o     = (state_q == RUN);
   assign halted_o    = (state_q == HALT);
   assign rf_wen_o    = wen_q;
   assign rd_o        = rd_q;
   assign rf_wdata_o  = wdata_q;
   assign good_trap_o = good_q;
   assign exit_pc_o   = exit_pc_q;
   assign exit_code_o = exit_code_q;
   assign retired_o   = retired_q;

   // Acceptance, exit squash, collision resolution, counter and halt capture.
   always_comb begin
      acc         = valid_i & {NPORT{ready_o}};
      commit      = '0;
      wen_raw     = '0;
      wen_d       = '0;
      exit_any    = 1'b0;
      exit_pc_sel = '0;
      n_commit    = '0;
      // Oldest exit wins; the exiting channel itself still commits.
      for (int k = 0; k < NPORT; k++) begin
         if (acc[k] && !exit_any) begin
            commit[k] = 1'b1;
            if (exit_i[k]) begin
               exit_any    = 1'b1;
               exit_pc_sel = pc_i[k*XLEN +: XLEN];
            end
         end
      end
      for (int k = 0; k < NPORT; k++) begin
         wen_raw[k] = commit[k] && rf_wen_i[k] && (rd_i[k*5 +: 5] != 5'd0);
         n_commit   = n_commit + CNT_W'(commit[k]);
      end
      // A younger writer to the same rd shadows an older one.
      for (int k = 0; k < NPORT; k++) begin
         wen_d[k] = wen_raw[k];
         for (int j = k + 1; j < NPORT; j++) begin
            if (wen_raw[j] && (rd_i[j*5 +: 5] == rd_i[k*5 +: 5]))
               wen_d[k] = 1'b0;
         end
      end
      rd_d        = rd_i;
      wdata_d     = rf_wdata_i;
      retired_d   = retired_q + n_commit;
      state_d     = exit_any ? HALT : state_q;
      good_d      = exit_any ? (a0_i == '0) : good_q;
      exit_pc_d   = exit_any ? exit_pc_sel  : exit_pc_q;
      exit_code_d = exit_any ? a0_i         : exit_code_q;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wen_q       <= '0;
         rd_q        <= '0;
         wdata_q     <= '0;
         good_q      <= 1'b0;
         exit_pc_q   <= '0;
         exit_code_q <= '0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
         good_q      <= good_d;
         exit_pc_q   <= exit_pc_d;
         exit_code_q <= exit_code_d;
         retired_q   <= retired_d;
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit (NPORT=2, XLEN=64, CNT_W=64).
module tb_wb_commit;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   valid_i = '0, rf_wen_i = '0, exit_i = '0;
   logic [9:0]   rd_i = '0;
   logic [127:0] rf_wdata_i = '0, pc_i = '0;
   logic [63:0]  a0_i = '0;
   logic         ready_o, halted_o, good_trap_o;
   logic [1:0]   rf_wen_o;
   logic [9:0]   rd_o;
   logic [127:0] rf_wdata_o;
   logic [63:0]  exit_pc_o, exit_code_o, retired_o;

   wb_commit #(.XLEN(64), .NPORT(2), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .rf_wen_i(rf_wen_i), .rd_i(rd_i), .rf_wdata_i(rf_wdata_i), .pc_i(pc_i),
      .exit_i(exit_i), .a0_i(a0_i), .rf_wen_o(rf_wen_o), .rd_o(rd_o),
      .rf_wdata_o(rf_wdata_o), .halted_o(halted_o), .good_trap_o(good_trap_o),
      .exit_pc_o(exit_pc_o), .exit_code_o(exit_code_o), .retired_o(retired_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   wen;
      logic [9:0]   rd;
      logic [127:0] wd;
      logic [63:0]  ret;
      logic         halt;
      logic         good;
      logic         rdy;
      logic [63:0]  pc;
      logic [63:0]  code;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: one edge after each driven vector the registered outputs are compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_wen_o",    {126'd0, rf_wen_o},   {126'd0, e.wen});
            chk("rd_o",        {118'd0, rd_o},       {118'd0, e.rd});
            chk("rf_wdata_o",  rf_wdata_o,           e.wd);
            chk("retired_o",   {64'd0, retired_o},   {64'd0, e.ret});
            chk("halted_o",    {127'd0, halted_o},   {127'd0, e.halt});
            chk("good_trap_o", {127'd0, good_trap_o},{127'd0, e.good});
            chk("ready_o",     {127'd0, ready_o},    {127'd0, e.rdy});
            chk("exit_pc_o",   {64'd0, exit_pc_o},   {64'd0, e.pc});
            chk("exit_code_o", {64'd0, exit_code_o}, {64'd0, e.code});
         end
      end
   end

   // Drive one vector at the falling edge and push its expected registered response.
   task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] ex,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] a0,
                        input logic [1:0] e_wen, input logic [63:0] e_ret,
                        input logic e_halt, input logic e_good,
                        input logic [63:0] e_pc, input logic [63:0] e_code);
      exp_t e;
      @(negedge clk);
      valid_i = v; rf_wen_i = w; exit_i = ex;
      rd_i = {r1, r0}; rf_wdata_i = {d1, d0}; pc_i = {p1, p0}; a0_i = a0;
      e.wen = e_wen; e.rd = {r1, r0}; e.wd = {d1, d0}; e.ret = e_ret;
      e.halt = e_halt; e.good = e_good; e.rdy = !e_halt; e.pc = e_pc; e.code = e_code;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_retired", {64'd0, retired_o}, 128'd0);
      chk("rst_wen",     {126'd0, rf_wen_o}, 128'd0);
      chk("rst_halted",  {127'd0, halted_o}, 128'd0);
      chk("rst_ready",   {127'd0, ready_o},  128'd1);
      @(negedge clk);
      rst_n = 1'b1;

      //     valid  wen    exit   r0 r1  d0     d1     p0            p1            a0    e_wen  ret halt good pc            code
      drive(2'b11, 2'b11, 2'b00, 5,  6,  'hAA,  'hBB,  'h80000000,   'h80000004,   0,    2'b11, 2,  0,   0,   0,            0);
      drive(2'b11, 2'b11, 2'b00, 7,  7,  'h1,   'h2,   'h80000008,   'h8000000c,   0,    2'b10, 4,  0,   0,   0,            0);
      drive(2'b01, 2'b01, 2'b00, 0,  0,  'hCC,  'h0,   'h80000000,   0,            0,    2'b00, 5,  0,   0,   0,            0);
      drive(2'b10, 2'b11, 2'b00, 9,  9,  'hDD,  'hEE,  0,            'h80000004,   0,    2'b10, 6,  0,   0,   0,            0);
      drive(2'b11, 2'b01, 2'b00, 3,  3,  'h33,  'h34,  0,            0,            0,    2'b01, 8,  0,   0,   0,            0);
      // ch0 exits with a0=0: ch1 squashed, only ch0 retires
      drive(2'b11, 2'b10, 2'b01, 1,  8,  'h11,  'h88,  'h80000010,   'h80000014,   0,    2'b00, 9,  1,   1,   'h80000010,   0);
      // HALT ignores everything; captured values hold despite a0 changing
      drive(2'b11, 2'b11, 2'b11, 5,  6,  'h55,  'h66,  'h1,          'h2,          7,    2'b00, 9,  1,   1,   'h80000010,   0);
      drive(2'b11, 2'b11, 2'b00, 2,  4,  'h22,  'h44,  'h3,          'h4,          7,    2'b00, 9,  1,   1,   'h80000010,   0);
      drain();

      // Asynchronous reset pulse in the middle of a HALT cycle
      @(posedge clk);
      #3;
      valid_i = 2'b11; rf_wen_i = 2'b11; exit_i = 2'b00; rd_i = {5'd6, 5'd5};
      rst_n = 1'b0;
      #1;
      chk("arst_wen",     {126'd0, rf_wen_o},   128'd0);
      chk("arst_rd",      {118'd0, rd_o},       128'd0);
      chk("arst_wdata",   rf_wdata_o,           128'd0);
      chk("arst_halted",  {127'd0, halted_o},   128'd0);
      chk("arst_good",    {127'd0, good_trap_o},128'd0);
      chk("arst_pc",      {64'd0, exit_pc_o},   128'd0);
      chk("arst_code",    {64'd0, exit_code_o}, 128'd0);
      chk("arst_retired", {64'd0, retired_o},   128'd0);
      chk("arst_ready",   {127'd0, ready_o},    128'd1);
      valid_i = '0; rf_wen_i = '0;
      #2;
      rst_n = 1'b1;

      // First edge after release with nothing presented: no write
      drive(2'b00, 2'b11, 2'b00, 5,  6,  'h0,   'h0,   0,            0,            0,    2'b00, 0,  0,   0,   0,            0);
      // ch1 exits with a0=3 and writes; ch0 older also writes
      drive(2'b11, 2'b11, 2'b10, 4,  10, 'h44,  'h55,  'h8000001c,   'h80000020,   3,    2'b11, 2,  1,   0,   'h80000020,   3);
      drive(2'b11, 2'b11, 2'b00, 12, 13, 'h12,  'h13,  'h5,          'h6,          0,    2'b00, 2,  1,   0,   'h80000020,   3);
      drive(2'b01, 2'b01, 2'b00, 14, 0,  'h14,  'h0,   'h7,          'h8,          0,    2'b00, 2,  1,   0,   'h80000020,   3);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
